// File: rtl/dot_matrix_scanner_if.sv
// Host-side bus of the dot-matrix scanner: row writes, bank swap handshake
// and the registered panel drive outputs.
interface dot_matrix_scanner_if #(
  parameter int ROWS = 7,
  parameter int COLS = 30,
  parameter int RW   = $clog2(ROWS)
);
  logic            enable;
  logic            wr_en;
  logic [RW-1:0]   wr_row;
  logic [COLS-1:0] wr_data;
  logic            swap_req;
  logic            swap_done;
  logic            swap_pending;
  logic            frame_start;
  logic [ROWS-1:0] row_out;
  logic [COLS-1:0] col_out;

  modport master (
    output enable, wr_en, wr_row, wr_data, swap_req,
    input  swap_done, swap_pending, frame_start, row_out, col_out
  );

  modport slave (
    input  enable, wr_en, wr_row, wr_data, swap_req,
    output swap_done, swap_pending, frame_start, row_out, col_out
  );
endinterface

// File: rtl/dot_matrix_scanner.sv
// Row-scanning LED matrix driver with a double-buffered frame store.
// Each row dwell is a blanking gap followed by active-low column drive.
module dot_matrix_scanner #(
  parameter int ROWS         = 7,
  parameter int COLS         = 30,
  parameter int SCAN_DIV     = 1024,
  parameter int BLANK_CYCLES = 4,
  parameter int RW           = $clog2(ROWS)
) (
  input  logic                 clk,
  input  logic                 rst,
  dot_matrix_scanner_if.slave  bus
);
  localparam int            TW      = $clog2(SCAN_DIV);
  localparam logic [TW-1:0] T_LAST  = TW'(SCAN_DIV - 1);
  localparam logic [TW-1:0] T_BLAST = TW'(BLANK_CYCLES - 1);
  localparam logic [RW-1:0] R_LAST  = RW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t          state, state_n;
  logic [RW-1:0]   row, row_n;
  logic [TW-1:0]   timer, timer_n;
  logic            bank_sel;
  logic            pending;
  logic [COLS-1:0] mem [2][ROWS];
  logic            boundary, entering, fire, wr_hit;
  logic [COLS-1:0] front_row;
  logic [ROWS-1:0] onehot;

  // Timer spans the whole dwell: BLANK below BLANK_CYCLES, DRIVE above.
  always_comb begin
    state_n  = state;
    row_n    = row;
    timer_n  = timer;
    boundary = 1'b0;
    entering = 1'b0;
    if (!bus.enable) begin
      state_n = IDLE;
      row_n   = '0;
      timer_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          row_n    = '0;
          timer_n  = '0;
          entering = 1'b1;
          state_n  = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
        end
        BLANK: begin
          timer_n = timer + 1'b1;
          if (timer == T_BLAST) state_n = DRIVE;
        end
        DRIVE: begin
          if (timer == T_LAST) begin
            timer_n = '0;
            state_n = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
            if (row == R_LAST) begin
              row_n    = '0;
              boundary = 1'b1;
            end else begin
              row_n = row + 1'b1;
            end
          end else begin
            timer_n = timer + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign fire   = pending & (boundary | (state == IDLE));
  assign wr_hit = bus.wr_en & (int'(bus.wr_row) < ROWS);

  // A write coinciding with a swap lands in the bank that becomes front.
  always_comb begin
    front_row = mem[bank_sel ^ fire][row_n];
    if (fire && wr_hit && (bus.wr_row == row_n)) front_row = bus.wr_data;
    onehot        = '0;
    onehot[row_n] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      row              <= '0;
      timer            <= '0;
      bank_sel         <= 1'b0;
      pending          <= 1'b0;
      bus.swap_done    <= 1'b0;
      bus.swap_pending <= 1'b0;
      bus.frame_start  <= 1'b0;
      bus.row_out      <= '0;
      bus.col_out      <= '1;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROWS; r++)
          mem[b][r] <= '0;
    end else begin
      state            <= state_n;
      row              <= row_n;
      timer            <= timer_n;
      bank_sel         <= bank_sel ^ fire;
      pending          <= bus.swap_req | (pending & ~fire);
      bus.swap_pending <= bus.swap_req | (pending & ~fire);
      bus.swap_done    <= fire;
      bus.frame_start  <= entering | boundary;
      if (state_n == DRIVE) begin
        bus.row_out <= onehot;
        bus.col_out <= ~front_row;
      end else begin
        bus.row_out <= '0;
        bus.col_out <= '1;
      end
      if (wr_hit) mem[~bank_sel][bus.wr_row] <= bus.wr_data;
    end
  end
endmodule

// File: doc/dot_matrix_scanner.md
# dot_matrix_scanner

Parametrised row-scanning driver for multi-panel LED dot-matrix displays. It holds a double-buffered frame store that a host writes one row at a time, and cycles through the rows with a one-hot row strobe. Each row is driven with active-low column data and preceded by a blanking gap that suppresses ghosting. It sits between the display-content logic and the panel pins, and supports any row count, column count and dwell time.

## Interface
- ROWS, 7, number of scanned rows (≥2)
- COLS, 30, total columns across all panels (e.g. 6 panels × 5)
- SCAN_DIV, 1024, clock cycles per row dwell (≥2)
- BLANK_CYCLES, 4, blank cycles at the start of each dwell (< SCAN_DIV)
- RW, $clog2(ROWS), row index width (derived)

Ports:
- clk  in  1  the design's single clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  1 = scan; 0 = outputs blanked
- wr_en  in  1  write one row of the back bank
- wr_row  in  RW  target row; values ≥ ROWS are ignored
- wr_data  in  COLS  row pixels, 1 = LED on
- swap_req  in  1  request a front/back bank swap at the next frame boundary
- swap_done  out  1  one-cycle pulse when a swap takes effect
- swap_pending  out  1  a swap is latched and waiting
- frame_start  out  1  one-cycle pulse in the first cycle of row 0
- row_out  out  ROWS  one-hot row strobe, active-high
- col_out  out  COLS  column drive, active-low (1 = off)

## Operation
- Storage: two banks of ROWS × COLS bits, bank_sel selects the front bank.
  - Writes always go to the back bank, which is bank !bank_sel.
  - The front bank is only ever read.
- FSM states: IDLE, BLANK, DRIVE.
  - IDLE: row_out = 0 and col_out = all ones. Row index and timer are held at 0. When enable = 1, go to BLANK with row 0.
  - BLANK: row_out = 0 and col_out = all ones. Lasts BLANK_CYCLES cycles, then go to DRIVE.
  - DRIVE: row_out = one-hot(row), col_out = ~front[row]. Lasts SCAN_DIV − BLANK_CYCLES cycles, then go to BLANK.
  - On each DRIVE→BLANK transition, the row index advances. At ROWS−1 it wraps to 0; this is the frame boundary.
  - If BLANK_CYCLES = 0, BLANK is skipped and DRIVE lasts SCAN_DIV cycles.
- enable = 0 in any state: on the next edge go to IDLE and clear the row index and timer. The frame stores are untouched.
- Swap handshake:
  - swap_req = 1 sets swap_pending. Further requests while pending are merged.
  - At the frame-boundary edge, or on any edge while in IDLE: bank_sel toggles, swap_pending clears, and swap_done pulses for one cycle.
  - A swap_req arriving on the boundary edge itself is held for the following boundary.
- Simultaneous write and swap on the same edge: the write lands in the pre-swap back bank, so it becomes visible immediately after the swap.
- Out-of-range wr_row: no storage changes.
- Reset:
  - Both banks are cleared to 0, and bank_sel = 0.
  - swap_pending = swap_done = frame_start = 0.
  - row_out = 0, col_out = all ones, state = IDLE.
  - Reset asserted mid-scan blanks the outputs on the next edge.

## Timing
- All outputs are registered.
- Row period is exactly SCAN_DIV cycles; frame period is ROWS × SCAN_DIV cycles.
- enable rising at edge N puts the FSM in BLANK, row 0 from edge N+1. frame_start is high in that cycle.
- Row 0 drives from edge N+1+BLANK_CYCLES.
- A write to the back bank has no visible effect until after a swap.
- First drive cycle after a swap shows the new bank. col_out reflects the new bank at the first DRIVE cycle of row 0.
- swap_done is coincident with frame_start when enabled. In IDLE, swap_done is asserted one cycle after the swap_req edge.
- Timer width is $clog2(SCAN_DIV). The counter wraps exactly at SCAN_DIV−1, with no off-by-one dwell.

## Test plan
Bench parameters: ROWS=7, COLS=30, SCAN_DIV=8, BLANK_CYCLES=2.
- Reset check: hold rst = 1 for 3 cycles. Required: row_out = 0, col_out = 30'h3FFFFFFF, swap_pending = 0, swap_done = 0.
- Basic scan: write rows 0–6 with distinct patterns (row r = 30'h1 << r), swap in IDLE, then enable.
  - swap_done pulses once.
  - Each row shows 2 blank cycles, then 6 cycles of row_out = 1<<r and col_out = ~(1<<r).
  - frame_start is seen every 56 cycles.
- Double buffering mid-frame: while scanning, write 30'h2AAAAAAA to row 3 of the back bank and assert swap_req during row 2.
  - Displayed data stays unchanged through row 6.
  - At the next row 0, swap_done = 1 and row 3 later drives ~30'h2AAAAAAA.
- Boundary collision: on the frame-boundary edge, assert wr_en (row 0, 30'h3FFFFFFF) together with a previously pending swap.
  - The swapped-in row 0 drives col_out = 0.
  - A swap_req on that same edge leaves swap_pending = 1 for the next frame.
- Enable drop and bad write: deassert enable during DRIVE of row 4.
  - Next cycle: outputs are blank and the FSM is in IDLE.
  - Re-enable: scan restarts at row 0 with frame_start.
  - wr_row = 7 writes change nothing.
- Mid-scan reset: assert rst during DRIVE. Required: outputs blank on the next edge, and both banks read back as 0 after re-enable.
